// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module : icache_pkg
// Purpose: Shared bus widths, default geometry and refill FSM state encoding
//          for the instruction cache slice.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package icache_pkg;

  localparam int MEM_ADDR_BUS      = 32;  // memory address bus width
  localparam int MEM_DATA_BUS      = 32;  // memory data bus width
  localparam int ICACHE_INDEX_BITS = 7;   // default line index width

  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } ic_state_e;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// Module : icache_if / icache_mem_if
// Purpose: icache_if     - IF stage <-> instruction cache request/response
//          icache_mem_if - instruction cache <-> memory controller fetch port
// Ports  : icache_if.master  (IF stage)    drives if_req, if_pc, if_cancel,
//                                           invalidate; sees inst_ready,
//                                           inst, busy
//          icache_if.slave   (cache)       mirror of master
//          icache_mem_if.master (cache)    drives mem_if_read, mem_if_addr;
//                                           sees mem_if_ready, mem_if_data
//          icache_mem_if.slave  (mem ctrl) mirror of master
// Rev    : 1.0  initial release
// ============================================================================
interface icache_if
  import icache_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS
) ();
  logic                    if_req;
  logic [ADDR_W-1:0]       if_pc;
  logic                    if_cancel;
  logic                    invalidate;
  logic                    inst_ready;
  logic [MEM_DATA_BUS-1:0] inst;
  logic                    busy;

  modport master (
    output if_req, if_pc, if_cancel, invalidate,
    input  inst_ready, inst, busy
  );

  modport slave (
    input  if_req, if_pc, if_cancel, invalidate,
    output inst_ready, inst, busy
  );
endinterface : icache_if

interface icache_mem_if
  import icache_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS
) ();
  logic                    mem_if_read;
  logic [ADDR_W-1:0]       mem_if_addr;
  logic                    mem_if_ready;
  logic [MEM_DATA_BUS-1:0] mem_if_data;

  modport master (
    output mem_if_read, mem_if_addr,
    input  mem_if_ready, mem_if_data
  );

  modport slave (
    input  mem_if_read, mem_if_addr,
    output mem_if_ready, mem_if_data
  );
endinterface : icache_mem_if
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module : icache_array
// Purpose: Valid / tag / data storage for a direct-mapped, one-word-per-line
//          instruction cache. Synchronous write, combinational read.
// Ports  : clock, reset   - clock, synchronous active-high reset (valid only)
//          clear_all_i    - clear every valid bit at the next edge
//          we_i, widx_i,
//          wtag_i, wdata_i- line write port (sets valid)
//          ridx_i         - read index
//          rvalid_o, rtag_o, rdata_o - combinational read of line ridx_i
// Rev    : 1.0  initial release
// ============================================================================
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_W      = MEM_ADDR_BUS - ICACHE_INDEX_BITS - 2,
  parameter int DATA_W     = MEM_DATA_BUS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_all_i,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] widx_i,
  input  logic [TAG_W-1:0]      wtag_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [INDEX_BITS-1:0] ridx_i,
  output logic                  rvalid_o,
  output logic [TAG_W-1:0]      rtag_o,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // A clear on the same edge as a write wins: a refill that completes with a
  // pending invalidate must leave its own line invalid too.
  always_ff @(posedge clock) begin
    if (reset || clear_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdata_o  = data_q[ridx_i];

endmodule : icache_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module : icache
// Purpose: Direct-mapped, one-word-per-line instruction cache between the IF
//          stage and the memory controller fetch port. Hits answer in one
//          cycle; misses issue a single 4-byte fetch held until the
//          controller returns the word.
// Ports  : clock, reset - clock, synchronous active-high reset
//          fetch        - icache_if.slave: if_req/if_pc/if_cancel/invalidate
//                         in, inst_ready/inst/busy out
//          mem          - icache_mem_if.master: mem_if_read/mem_if_addr out,
//                         mem_if_ready/mem_if_data in
// Rev    : 1.0  initial release
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_W     = MEM_ADDR_BUS
) (
  input  logic         clock,
  input  logic         reset,
  icache_if.slave      fetch,
  icache_mem_if.master mem
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  ic_state_e               state_q;
  logic                    inst_ready_q;
  logic                    busy_q;
  logic                    mem_read_q;
  logic [ADDR_W-1:0]       mem_addr_q;
  logic [MEM_DATA_BUS-1:0] inst_q;
  logic                    drop_q;      // IF cancelled the outstanding refill
  logic                    pend_inv_q;  // invalidate arrived during a refill

  logic [INDEX_BITS-1:0]   rd_index;
  logic [TAG_W-1:0]        rd_tag_req;
  logic                    line_valid;
  logic [TAG_W-1:0]        line_tag;
  logic [MEM_DATA_BUS-1:0] line_data;
  logic                    hit;
  logic                    refill_done;
  logic                    clear_all;
  logic                    drop_now;
  logic                    unused_addr_lsb;

  assign rd_index   = fetch.if_pc[INDEX_BITS+1:2];
  assign rd_tag_req = fetch.if_pc[ADDR_W-1:INDEX_BITS+2];

  // An invalidate in the same cycle as a request forces a miss so that the
  // request never observes a line that is being cleared.
  assign hit = line_valid && (line_tag == rd_tag_req) && !fetch.invalidate;

  assign refill_done = (state_q == IC_REFILL) && mem.mem_if_ready;

  assign clear_all = ((state_q == IC_IDLE) && fetch.invalidate) ||
                     (refill_done && (pend_inv_q || fetch.invalidate));

  // A cancel arriving on the completion edge still suppresses the response.
  assign drop_now = drop_q || fetch.if_cancel;

  assign unused_addr_lsb = ^{fetch.if_pc[1:0], mem_addr_q[1:0]};

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (MEM_DATA_BUS)
  ) u_array (
    .clock       (clock),
    .reset       (reset),
    .clear_all_i (clear_all),
    .we_i        (refill_done),
    .widx_i      (mem_addr_q[INDEX_BITS+1:2]),
    .wtag_i      (mem_addr_q[ADDR_W-1:INDEX_BITS+2]),
    .wdata_i     (mem.mem_if_data),
    .ridx_i      (rd_index),
    .rvalid_o    (line_valid),
    .rtag_o      (line_tag),
    .rdata_o     (line_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IC_IDLE;
      inst_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      inst_q       <= '0;
      drop_q       <= 1'b0;
      pend_inv_q   <= 1'b0;
    end else begin
      inst_ready_q <= 1'b0;
      case (state_q)
        IC_IDLE: begin
          if (fetch.if_req) begin
            if (hit) begin
              inst_q       <= line_data;
              inst_ready_q <= 1'b1;
            end else begin
              state_q    <= IC_REFILL;
              mem_read_q <= 1'b1;
              mem_addr_q <= {fetch.if_pc[ADDR_W-1:2], 2'b00};
              busy_q     <= 1'b1;
              drop_q     <= 1'b0;
              pend_inv_q <= 1'b0;
            end
          end
        end
        IC_REFILL: begin
          // The request is never withdrawn: the controller may be mid-transfer.
          if (fetch.if_cancel) drop_q <= 1'b1;
          if (fetch.invalidate) pend_inv_q <= 1'b1;
          if (mem.mem_if_ready) begin
            state_q    <= IC_IDLE;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            pend_inv_q <= 1'b0;
            if (!drop_now) begin
              inst_q       <= mem.mem_if_data;
              inst_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= IC_IDLE;
      endcase
    end
  end

  assign fetch.inst_ready = inst_ready_q;
  assign fetch.inst       = inst_q;
  assign fetch.busy       = busy_q;
  assign mem.mem_if_read  = mem_read_q;
  assign mem.mem_if_addr  = mem_addr_q;

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module : tb_icache
// Purpose: Self-checking bench for icache: directed vector table, hand-written
//          reset / stray-response sequences, and randomized fetches checked
//          against a line-level reference model of the cache.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_icache;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  icache_if     #(.ADDR_W(32)) fif ();
  icache_mem_if #(.ADDR_W(32)) mif ();

  icache #(
    .INDEX_BITS (7),
    .ADDR_W     (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .fetch (fif),
    .mem   (mif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one record per line, addressed by plain arithmetic.
  bit          m_valid [128];
  logic [22:0] m_tag   [128];
  logic [31:0] m_data  [128];

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc / 4) % 128);
  endfunction

  function automatic logic [22:0] tag_of(input logic [31:0] pc);
    return 23'(pc / 512);
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete IF transaction. Called at #1 after a rising edge.
  task automatic do_fetch(input string nm, input logic [31:0] pc, input int lat,
                          input logic [31:0] mdata, input bit cancel, input bit inv_req,
                          input bit inv_refill, input bit exp_hit, input logic [31:0] exp_data);
    int          idx;
    logic [22:0] tg;
    idx = line_of(pc);
    tg  = tag_of(pc);
    fif.if_req     = 1'b1;
    fif.if_pc      = pc;
    fif.invalidate = inv_req;
    @(posedge clock); #1;
    fif.invalidate = 1'b0;
    if (inv_req) model_clear();
    if (exp_hit) begin
      check({nm, " hit inst_ready"}, 32'(fif.inst_ready), 32'd1);
      check({nm, " hit inst"}, fif.inst, exp_data);
      check({nm, " hit mem_if_read"}, 32'(mif.mem_if_read), 32'd0);
      fif.if_req = 1'b0;
    end else begin
      check({nm, " miss mem_if_read"}, 32'(mif.mem_if_read), 32'd1);
      check({nm, " miss mem_if_addr"}, mif.mem_if_addr, {pc[31:2], 2'b00});
      check({nm, " miss busy"}, 32'(fif.busy), 32'd1);
      check({nm, " miss inst_ready"}, 32'(fif.inst_ready), 32'd0);
      for (int k = 0; k < lat; k++) begin
        if (k == 0) begin
          if (cancel) begin
            fif.if_cancel = 1'b1;
            fif.if_req    = 1'b0;
          end
          if (inv_refill) fif.invalidate = 1'b1;
        end
        @(posedge clock); #1;
        fif.if_cancel  = 1'b0;
        fif.invalidate = 1'b0;
        check({nm, " wait hold"}, {mif.mem_if_addr[31:2], fif.busy, mif.mem_if_read},
              {pc[31:2], 1'b1, 1'b1});
        check({nm, " wait inst_ready"}, 32'(fif.inst_ready), 32'd0);
      end
      mif.mem_if_ready = 1'b1;
      mif.mem_if_data  = mdata;
      @(posedge clock); #1;
      mif.mem_if_ready = 1'b0;
      check({nm, " done mem_if_read"}, 32'(mif.mem_if_read), 32'd0);
      check({nm, " done busy"}, 32'(fif.busy), 32'd0);
      check({nm, " done inst_ready"}, 32'(fif.inst_ready), cancel ? 32'd0 : 32'd1);
      if (!cancel) check({nm, " done inst"}, fif.inst, exp_data);
      fif.if_req   = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = mdata;
      if (inv_refill) model_clear();
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] mdata;
    bit          cancel;
    bit          inv_req;
    bit          inv_refill;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] r_pc;
  logic [31:0] r_exp;
  int          r_lat;
  bit          r_c, r_iq, r_ir, r_hit;
  int          r_idx;

  initial begin
    //           pc          lat mdata          cancel invreq invref hit exp
    vecs[0]  = '{32'h0000_0010, 5, 32'h00A0_0093, 0, 0, 0, 0, 32'h00A0_0093}; // cold miss
    vecs[1]  = '{32'h0000_0010, 0, 32'h0,         0, 0, 0, 1, 32'h00A0_0093}; // hit after fill
    vecs[2]  = '{32'h0000_0210, 2, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'hDEAD_BEEF}; // conflict
    vecs[3]  = '{32'h0000_0010, 1, 32'h00A0_0093, 0, 0, 0, 0, 32'h00A0_0093}; // evicted
    vecs[4]  = '{32'h0000_0040, 4, 32'h1234_5678, 1, 0, 0, 0, 32'h0};         // cancelled
    vecs[5]  = '{32'h0000_0040, 0, 32'h0,         0, 0, 0, 1, 32'h1234_5678}; // filled anyway
    vecs[6]  = '{32'h0000_0010, 0, 32'h0,         0, 0, 0, 1, 32'h00A0_0093};
    vecs[7]  = '{32'h0000_0010, 3, 32'h00A0_0093, 0, 1, 0, 0, 32'h00A0_0093}; // inv in idle
    vecs[8]  = '{32'h0000_0080, 4, 32'h1111_2222, 0, 0, 1, 0, 32'h1111_2222}; // inv in refill
    vecs[9]  = '{32'h0000_0080, 0, 32'h3333_4444, 0, 0, 0, 0, 32'h3333_4444}; // cleared line
    vecs[10] = '{32'h0000_0010, 2, 32'h00A0_0093, 0, 0, 0, 0, 32'h00A0_0093};
    vecs[11] = '{32'h0000_0040, 20, 32'h1234_5678, 0, 0, 0, 0, 32'h1234_5678}; // stalled ctrl

    reset            = 1'b1;
    fif.if_req       = 1'b0;
    fif.if_pc        = '0;
    fif.if_cancel    = 1'b0;
    fif.invalidate   = 1'b0;
    mif.mem_if_ready = 1'b0;
    mif.mem_if_data  = '0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    check("reset outputs", {fif.inst_ready, fif.busy, mif.mem_if_read}, 32'd0);
    check("reset inst", fif.inst, 32'd0);
    check("reset mem_if_addr", mif.mem_if_addr, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[i])
      do_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].lat, vecs[i].mdata,
               vecs[i].cancel, vecs[i].inv_req, vecs[i].inv_refill,
               vecs[i].exp_hit, vecs[i].exp_data);

    // Reset while a refill is outstanding drops the request on the same edge.
    fif.if_req = 1'b1;
    fif.if_pc  = 32'h0000_0100;
    @(posedge clock); #1;
    check("rst-mid read up", 32'(mif.mem_if_read), 32'd1);
    @(posedge clock); #1;
    reset      = 1'b1;
    fif.if_req = 1'b0;
    @(posedge clock); #1;
    check("rst-mid read dropped", 32'(mif.mem_if_read), 32'd0);
    check("rst-mid busy", 32'(fif.busy), 32'd0);
    reset = 1'b0;
    model_clear();
    @(posedge clock); #1;
    do_fetch("post-reset", 32'h0000_0010, 2, memword(32'h10), 0, 0, 0, 0, memword(32'h10));

    // A stray controller response in IDLE must not fill a line.
    mif.mem_if_ready = 1'b1;
    mif.mem_if_data  = 32'hCAFE_F00D;
    @(posedge clock); #1;
    mif.mem_if_ready = 1'b0;
    check("stray inst_ready", 32'(fif.inst_ready), 32'd0);
    check("stray busy", 32'(fif.busy), 32'd0);
    do_fetch("after-stray", 32'h0000_0300, 1, memword(32'h300), 0, 0, 0, 0, memword(32'h300));

    // Randomized fetches over a small, conflict-heavy address set.
    for (int i = 0; i < 200; i++) begin
      r_pc  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2);
      r_lat = int'($urandom_range(0, 6));
      r_iq  = ($urandom_range(0, 9) == 0);
      r_c   = (r_lat > 0) && ($urandom_range(0, 5) == 0);
      r_ir  = (r_lat > 0) && ($urandom_range(0, 9) == 0);
      r_idx = line_of(r_pc);
      r_hit = !r_iq && m_valid[r_idx] && (m_tag[r_idx] == tag_of(r_pc));
      r_exp = r_hit ? m_data[r_idx] : memword(r_pc + 32'(i));
      do_fetch($sformatf("rnd%0d", i), r_pc, r_lat, memword(r_pc + 32'(i)),
               r_c, r_iq, r_ir, r_hit, r_exp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_icache
`default_nettype wire
